// File: rtl/q_reader.sv
// q_reader: consumer-side adapter for the CPU circular queue.
//
// Issues dequeue requests to the queue, captures the queue's registered
// one-cycle-late response (q_ready/q_out) and presents it downstream as a
// valid/ack stream. The queue's dequeue port cannot be stalled, so a small
// circular buffer absorbs any response already in flight when the consumer
// applies back-pressure.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   flush      synchronous discard of buffered and in-flight data
//   q_empty    queue empty flag (combinational from the queue)
//   q_ready    queue registered "dequeue produced data" flag
//   q_out      queue registered dequeue data
//   q_deq      dequeue request to the queue (combinational)
//   out_valid  buffer head holds valid data
//   out_data   buffer head data
//   out_ack    consumer takes the head this cycle (only when out_valid=1)
//   count      occupied buffer entries
module q_reader #(
    parameter int width = 32,
    parameter int depth = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       q_empty,
    input  logic                       q_ready,
    input  logic [width-1:0]           q_out,
    output logic                       q_deq,
    output logic                       out_valid,
    output logic [width-1:0]           out_data,
    input  logic                       out_ack,
    output logic [$clog2(depth+1)-1:0] count
);

    localparam int CW = $clog2(depth + 1);
    localparam int PW = $clog2(depth);
    localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(depth);
    localparam logic [PW-1:0] LAST_PTR  = PW'(depth - 1);

    // Circular pointer advance with wrap at depth-1 (depth need not be a power of two).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == LAST_PTR) begin
            r = {PW{1'b0}};
        end else begin
            r = p + PW'(1);
        end
        return r;
    endfunction

    logic [width-1:0] buf_q [depth];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             inflight_q, inflight_d;
    logic             pop_s;
    logic             cap_s;
    logic [CW:0]      occ_s;

    assign out_valid = (count_q != {CW{1'b0}});
    assign out_data  = buf_q[head_q];
    assign count     = count_q;

    // Dequeue issue, capture/pop qualification and next-state computation.
    always_comb begin
        pop_s = out_valid & out_ack;
        // A response is only real when we asked for it last cycle; q_ready
        // alone is stale because the queue holds it while idle.
        cap_s = inflight_q & q_ready & ~flush;
        // Occupancy the buffer will have once this cycle's pop retires and
        // the outstanding response lands; one extra bit so it never wraps.
        occ_s = {1'b0, count_q} - {{CW{1'b0}}, pop_s} + {{CW{1'b0}}, inflight_q};
        q_deq = ~rst & ~flush & ~q_empty & (occ_s < DEPTH_OCC);

        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        inflight_d = q_deq;

        if (flush) begin
            head_d     = {PW{1'b0}};
            tail_d     = {PW{1'b0}};
            count_d    = {CW{1'b0}};
            inflight_d = 1'b0;
        end else begin
            if (cap_s) begin
                tail_d = ptr_inc(tail_q);
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = ptr_inc(head_q);
            end else begin
                head_d = head_q;
            end
            count_d = count_q + {{(CW-1){1'b0}}, cap_s} - {{(CW-1){1'b0}}, pop_s};
        end
    end

    // Pointer, occupancy and in-flight state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= {PW{1'b0}};
            tail_q     <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
            inflight_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
        end
    end

    // Buffer storage: cleared on reset, written at the tail on capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < depth; i++) begin
                buf_q[i] <= {width{1'b0}};
            end
        end else if (cap_s) begin
            buf_q[tail_q] <= q_out;
        end else begin
            buf_q[tail_q] <= buf_q[tail_q];
        end
    end

endmodule

// File: tb/tb_q_reader.sv
// Scoreboard bench for q_reader: a behavioural queue model feeds the DUT,
// expected deliveries are queued when items are loaded, and a monitor
// compares every accepted output beat against the head of that queue.
module tb_q_reader;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        q_empty;
    logic        q_ready;
    logic [31:0] q_out;
    logic        q_deq;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ack;
    logic [1:0]  count;

    int checks;
    int errors;
    int ndeq;

    logic [31:0] mq[$];    // contents of the modelled circular queue
    logic [31:0] expq[$];  // expected delivery order

    q_reader #(.width(32), .depth(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .q_empty  (q_empty),
        .q_ready  (q_ready),
        .q_out    (q_out),
        .q_deq    (q_deq),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ack  (out_ack),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock: the queue model answers a dequeue seen at this edge with
    // registered ready/data; when idle it holds ready at its last value.
    task automatic tick();
        logic d;
        @(posedge clk);
        d = q_deq;
        #1;
        if (rst) begin
            q_ready = 1'b0;
        end else if (d) begin
            ndeq++;
            if (mq.size() > 0) begin
                q_out   = mq.pop_front();
                q_ready = 1'b1;
            end else begin
                q_ready = 1'b0;
            end
        end
        q_empty = (mq.size() == 0);
        #1;
    endtask

    task automatic load(input logic [31:0] v, input bit expect_it);
        mq.push_back(v);
        if (expect_it) expq.push_back(v);
        q_empty = 1'b0;
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ack) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL delivery unexpected actual=%0h required=none t=%0t", out_data, $time);
                end else begin
                    logic [31:0] e;
                    e = expq.pop_front();
                    if (out_data !== e) begin
                        errors++;
                        $display("FAIL delivery actual=%0h required=%0h t=%0t", out_data, e, $time);
                    end
                end
            end
        end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; flush = 1'b0; q_empty = 1'b1;
        q_ready = 1'b0; q_out = 32'h0; out_ack = 1'b0;
        checks = 0; errors = 0; ndeq = 0;
        fork
            monitor();
        join_none

        // Reset state, then an idle empty queue.
        #1;
        chk("rst_count", {30'd0, count}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_deq", {31'd0, q_deq}, 32'd0);
            chk("idle_valid", {31'd0, out_valid}, 32'd0);
            chk("idle_count", {30'd0, count}, 32'd0);
            chk("idle_data", out_data, 32'd0);
        end

        // Streaming: three items, consumer always ready.
        out_ack = 1'b1;
        load(32'h11, 1'b1); load(32'h22, 1'b1); load(32'h33, 1'b1);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("stream_deq", {31'd0, q_deq}, (i < 3) ? 32'd1 : 32'd0);
            chk("stream_valid", {31'd0, out_valid}, (i >= 2) ? 32'd1 : 32'd0);
            if (i == 2) chk("stream_data0", out_data, 32'h11);
            if (i == 3) chk("stream_data1", out_data, 32'h22);
            if (i == 4) chk("stream_data2", out_data, 32'h33);
            tick();
        end
        chk("stream_end_valid", {31'd0, out_valid}, 32'd0);
        chk("stream_end_count", {30'd0, count}, 32'd0);

        // Back-pressure: five items, consumer stalled, then released.
        out_ack = 1'b0;
        ndeq = 0;
        for (int i = 1; i <= 5; i++) load(32'h50 + i, 1'b1);
        #1;
        repeat (6) tick();
        chk("bp_ndeq", ndeq, 32'd2);
        chk("bp_count", {30'd0, count}, 32'd2);
        chk("bp_deq", {31'd0, q_deq}, 32'd0);
        chk("bp_head", out_data, 32'h51);
        out_ack = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_nogap", {31'd0, out_valid}, 32'd1);
            tick();
        end
        chk("bp_end_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_all_delivered", expq.size(), 32'd0);

        // Stale q_ready held high after the queue drains.
        load(32'h66, 1'b1);
        #1;
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            chk("stale_count", {30'd0, count}, 32'd0);
            chk("stale_valid", {31'd0, out_valid}, 32'd0);
            tick();
        end
        chk("stale_delivered", expq.size(), 32'd0);

        // Flush discards the response of the previous cycle's dequeue.
        load(32'hAB, 1'b0); load(32'hCD, 1'b1);
        #1;
        chk("flush_pre_deq", {31'd0, q_deq}, 32'd1);
        tick();
        flush = 1'b1;
        #1;
        chk("flush_deq", {31'd0, q_deq}, 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_count", {30'd0, count}, 32'd0);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        repeat (4) tick();
        chk("flush_after_delivered", expq.size(), 32'd0);

        // Asynchronous reset mid-cycle with a full buffer.
        out_ack = 1'b0;
        load(32'h71, 1'b0); load(32'h72, 1'b0);
        #1;
        repeat (3) tick();
        chk("arst_pre_count", {30'd0, count}, 32'd2);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_count", {30'd0, count}, 32'd0);
        chk("arst_data", out_data, 32'd0);
        mq.delete();
        q_ready = 1'b0;
        q_empty = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_count", {30'd0, count}, 32'd0);
        chk("post_rst_deq", {31'd0, q_deq}, 32'd0);
        chk("final_expq_empty", expq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
